// File: rtl/alu_seq.sv
// Purpose : handshaked execute-stage ALU. It computes ADD/SUB/logic/compare in one cycle, serial
//           shifts at 1 bit per cycle, and an optional iterative multiply.
// Latency : 1 cycle from accept to out_valid for simple ops; 1+k for a shift by k>0; 1+WIDTH for MUL.
// Backpr. : in_ready is low while an op is in flight. A result is held in DONE until out_ready=1.
//           A new op may be accepted on the same edge that retires the previous result.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in1, in2, ctrl captured on accept)
//   in1, in2 [WIDTH]      operands; the shift amount is in2[SHAMT_W-1:0]
//   ctrl [4]              opcode 0 ADD 1 SUB 2 XOR 3 OR 4 AND 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU A MUL, B-F -> 0
//   out_valid/out_ready   result handshake
//   ALU_out [WIDTH]       registered result
//   busy                  an op is in flight (state != IDLE)
// Configuration macro: ALU_MUL_EN. When it is defined, ctrl=A is a WIDTH-cycle shift-add multiply.
//   When it is undefined, ctrl=A returns 0 in one cycle and no multiplier datapath exists.

module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             busy
);

    // The counter holds either a shift amount (up to WIDTH-1) or the multiply iteration count (WIDTH).
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;     // shift operand, or the multiply accumulator
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               vld_q, vld_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifted right each iteration
`endif

    logic               accept;
    logic               slt_bit;
    logic               sltu_bit;
    logic               is_shift_in;
    logic               needs_exec;
    logic [SHAMT_W-1:0] shamt_in;
    logic [WIDTH-1:0]   quick_res;
    logic [WIDTH-1:0]   shift_nxt;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = vld_q;
    assign ALU_out   = res_q;

    assign slt_bit     = ($signed(in1) < $signed(in2));
    assign sltu_bit    = (in1 < in2);
    assign shamt_in    = in2[SHAMT_W-1:0];
    assign is_shift_in = (ctrl == OP_SLL) | (ctrl == OP_SRL) | (ctrl == OP_SRA);

    // Ops that cannot finish on the accept edge: a non-zero shift, and MUL when it is built.
`ifdef ALU_MUL_EN
    assign needs_exec = (is_shift_in & (shamt_in != '0)) | (ctrl == OP_MUL);
`else
    assign needs_exec = is_shift_in & (shamt_in != '0);
`endif

    // Result of any op that completes on the accept edge, computed straight from the inputs.
    always_comb begin
        quick_res = '0;
        case (ctrl)
            OP_ADD:  quick_res = in1 + in2;
            OP_SUB:  quick_res = in1 - in2;
            OP_XOR:  quick_res = in1 ^ in2;
            OP_OR:   quick_res = in1 | in2;
            OP_AND:  quick_res = in1 & in2;
            // Shifts only finish here when the amount is zero, so the result is in1 unchanged.
            OP_SLL, OP_SRL, OP_SRA: quick_res = in1;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            // Without the multiplier MUL is an unused opcode. With it, this value is never selected.
            OP_MUL:  quick_res = '0;
            default: quick_res = '0;
        endcase
    end

    // Shift the captured operand by one bit in the captured direction.
    always_comb begin
        shift_nxt = work_q;
        case (op_q)
            OP_SLL:  shift_nxt = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_nxt = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_nxt = work_q;
        endcase
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        count_d  = count_q;
        res_d    = res_q;
        vld_d    = vld_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif

        case (state_q)
            EXEC: begin
                count_d = count_q - CNT_W'(1);
                work_d  = shift_nxt;
`ifdef ALU_MUL_EN
                if (op_q == OP_MUL) begin
                    work_d   = work_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end
`endif
                // The last iteration writes straight into the result register.
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                    res_d   = work_d;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: ;
        endcase

        // An accept in DONE retires the old result. It overrides the DONE->IDLE move above.
        if (accept) begin
            op_d = ctrl;
            if (needs_exec) begin
                state_d = EXEC;
                vld_d   = 1'b0;
                work_d  = in1;
                count_d = CNT_W'(shamt_in);
`ifdef ALU_MUL_EN
                if (ctrl == OP_MUL) begin
                    work_d   = '0;
                    count_d  = CNT_W'(WIDTH);
                    mcand_d  = in1;
                    mplier_d = in2;
                end
`endif
            end else begin
                state_d = DONE;
                res_d   = quick_res;
                vld_d   = 1'b1;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            count_q  <= '0;
            res_q    <= '0;
            vld_q    <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            count_q  <= count_d;
            res_q    <= res_d;
            vld_q    <= vld_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Purpose : directed and random checks of alu_seq (WIDTH=32) against an arithmetic reference model.
// Latency : inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : random out_ready stalls of 0-2 cycles are applied on every result.

module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result, written with plain SystemVerilog operators.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic [4:0]         sh;
        sa = a;
        sh = b[4:0];
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a ^ b;
            4'h3: return a | b;
            4'h4: return a & b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return 32'(sa >>> sh);
            4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'hA: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from the accept edge to the first sample that shows out_valid.
    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op >= 4'h5 && op <= 4'h7) return 1 + int'(b[4:0]);
`ifdef ALU_MUL_EN
        if (op == 4'hA) return 33;
`endif
        return 1;
    endfunction

    // Run one op from IDLE to completion. The inputs are scrambled after the accept edge,
    // and out_ready is held low for `hold` extra cycles before the result is taken.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ev, input int el, input int hold, input string tag);
        int lat;
        ctrl = op; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom; ctrl = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(el));
        chk({tag, " value"}, ALU_out, ev);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, " stall value"}, ALU_out, ev);
            chk({tag, " stall valid"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk({tag, " retire"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int          seen_vld;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; ctrl = '0;

        // Reset state
        step(); step();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst ALU_out",   ALU_out, 32'd0);
        chk("rst in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst busy",      {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic arithmetic and compares
        run_op(4'h0, 32'd5, 32'd7, 32'd12, 1, 0, "add");
        run_op(4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 0, "sub");
        run_op(4'h8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0, "slt");
        run_op(4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, "sltu");

        // Serial shifts
        run_op(4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 0, "sra4");
        run_op(4'h5, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0, "sll0");
        run_op(4'h6, 32'h0000_0001, 32'd31, 32'd0, 32, 0, "srl31");

        // Back-to-back: ADD then SUB with in_valid held high
        ctrl = 4'h0; in1 = 32'd5; in2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("b2b add valid", {31'd0, out_valid}, 32'd1);
        chk("b2b add value", ALU_out, 32'd12);
        chk("b2b in_ready",  {31'd0, in_ready}, 32'd1);
        ctrl = 4'h1; in1 = 32'd3; in2 = 32'd5;
        step();
        in_valid = 1'b0;
        chk("b2b sub valid", {31'd0, out_valid}, 32'd1);
        chk("b2b sub value", ALU_out, 32'hFFFF_FFFE);
        step();
        chk("b2b drained", {31'd0, out_valid}, 32'd0);

        // Backpressure for three cycles, then retire with a simultaneous accept
        out_ready = 1'b0;
        ctrl = 4'h0; in1 = 32'd10; in2 = 32'd20; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp first", ALU_out, 32'd30);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp valid held", {31'd0, out_valid}, 32'd1);
            chk("bp value held", ALU_out, 32'd30);
            chk("bp in_ready",   {31'd0, in_ready}, 32'd0);
        end
        ctrl = 4'h2; in1 = 32'd1; in2 = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp ready w/ out_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp new valid", {31'd0, out_valid}, 32'd1);
        chk("bp new value", ALU_out, 32'd3);
        step();
        chk("bp drained", {31'd0, out_valid}, 32'd0);

        // Reset during EXEC cycle 5 of SLL by 20
        ctrl = 4'h5; in1 = 32'd1; in2 = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("midrst busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst busy",      {31'd0, busy}, 32'd0);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst ALU_out",   ALU_out, 32'd0);
        rst_n = 1'b1;
        seen_vld = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) seen_vld++;
        end
        chk("midrst no result", 32'(seen_vld), 32'd0);

        // Multiply (or unused opcode when the multiplier is not built)
`ifdef ALU_MUL_EN
        run_op(4'hA, 32'd6, 32'd7, 32'd42, 33, 0, "mul");
`else
        run_op(4'hA, 32'd6, 32'd7, 32'd0, 1, 0, "mul");
`endif
        run_op(4'hF, 32'd6, 32'd7, 32'd0, 1, 0, "op_f");

        // Random ops compared against the model, with random output stalls
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 0) rb = rb & 32'h0000_0007;
            run_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop, rb), int'($urandom_range(0, 2)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
